// File: rtl/rd_mem_pkg.sv
// Shared constants and the pipeline-stage struct macro for the rd_mem responder.
// The struct is a macro because its data width follows each instance's DATA_W.
`ifndef RD_MEM_PKG_SV
`define RD_MEM_PKG_SV

`define RD_PIPE_T(DW) struct packed { logic vld; logic [(DW)-1:0] data; }

package rd_mem_pkg;

   localparam int MAX_LATENCY = 4;

   function automatic bit latency_ok(input int lat);
      return (lat >= 1) && (lat <= MAX_LATENCY);
   endfunction

endpackage

`endif

// File: rtl/rd_if.sv
// Read request/response bundle between a reader (to_mem) and a memory (from_mem).
interface rd_if #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 32
);
   logic [ADDR_W-1:0] Addr;
   logic              Enable;
   logic [DATA_W-1:0] Data;
   logic              Valid;

   modport from_mem (input Addr, input Enable, output Data, output Valid);
   modport to_mem   (output Addr, output Enable, input Data, input Valid);
endinterface

// File: rtl/rd_mem_pipe.sv
// LATENCY-deep {valid, data} shift register; the output stage keeps its data
// between responses so the read bus never returns to 0 or picks up stale stages.
module rd_mem_pipe #(
   parameter int LATENCY = 1,
   parameter int DATA_W  = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_vld,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_vld,
   output logic [DATA_W-1:0] out_data
);

   typedef `RD_PIPE_T(DATA_W) rd_pipe_t;

   rd_pipe_t [LATENCY-1:0] pipe_q;
   rd_pipe_t [LATENCY-1:0] pipe_d;

   always_comb begin
      pipe_d[0].vld  = in_vld;
      pipe_d[0].data = in_data;
      for (int i = 1; i < LATENCY; i++) pipe_d[i] = pipe_q[i-1];
      // last stage only takes data that arrives with a valid
      if (!pipe_d[LATENCY-1].vld) pipe_d[LATENCY-1].data = pipe_q[LATENCY-1].data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pipe_q <= '0;
      else        pipe_q <= pipe_d;
   end

   assign out_vld  = pipe_q[LATENCY-1].vld;
   assign out_data = pipe_q[LATENCY-1].data;

endmodule

// File: rtl/rd_mem_responder.sv
// Flop-array memory serving rd_if reads with a fixed pipelined latency,
// one write port, optional write-to-read forwarding and a hard-zero word 0.
module rd_mem_responder
   import rd_mem_pkg::*;
#(
   parameter int ADDR_W  = 5,
   parameter int DATA_W  = 32,
   parameter int LATENCY = 1,
   parameter bit WR_FWD  = 1'b1,
   parameter bit ZERO_W0 = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   rd_if.from_mem            rd,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data
);

   localparam int DEPTH = 2 ** ADDR_W;

   if (!latency_ok(LATENCY)) begin : g_bad_latency
      $error("rd_mem_responder: LATENCY=%0d outside 1..%0d", LATENCY, MAX_LATENCY);
   end

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] mem_d [DEPTH];
   logic              wr_ok;
   logic              fwd_hit;
   logic              zero_hit;
   logic [DATA_W-1:0] snap;

   always_comb begin
      wr_ok = wr_en && !(ZERO_W0 && (wr_addr == '0));
      mem_d = mem_q;
      if (wr_ok) mem_d[wr_addr] = wr_data;
   end

   // array contents are deliberately not reset
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   // Snapshot is gated by Enable so an undriven Addr never reaches the pipe.
   always_comb begin
      fwd_hit  = WR_FWD && wr_en && (wr_addr == rd.Addr);
      zero_hit = ZERO_W0 && (rd.Addr == '0);
      snap     = '0;
      if (rd.Enable && !zero_hit) snap = fwd_hit ? wr_data : mem_q[rd.Addr];
   end

   rd_mem_pipe #(
      .LATENCY (LATENCY),
      .DATA_W  (DATA_W)
   ) u_pipe (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_vld   (rd.Enable),
      .in_data  (snap),
      .out_vld  (rd.Valid),
      .out_data (rd.Data)
   );

endmodule
